cla_operand_sequencer: RTL and testbench

//  Upstream front end for the 8-bit carry-lookahead adder core. Loads two NBYTES-wide

---
 rtl/cla_operand_sequencer.sv | 136 +++++++++++++
 tb/tb_cla_operand_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_operand_sequencer.sv
// cla_operand_sequencer
// Byte-serial front end for an external 8-bit carry-lookahead adder.
// Two NBYTES-wide operands are loaded one byte at a time over din.
// The adder is then driven LSB first, with the carry chained between bytes.
// The wide sum is returned byte-serially under a valid/ack handshake.
module cla_operand_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] din,
  input  logic       load_a,
  input  logic       load_b,
  input  logic       cin,
  input  logic       start,
  input  logic       out_ack,
  output logic [7:0] cla_a,
  output logic [7:0] cla_b,
  output logic       cla_cin,
  input  logic [7:0] cla_sum,
  input  logic       cla_cout,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       busy,
  output logic       cout_final,
  output logic       done
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  r_q, r_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cout_final_q, cout_final_d;
  logic          done_q, done_d;

  // State register; a low enable freezes every flop, including the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      r_q          <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      cout_final_q <= 1'b0;
      done_q       <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      r_q          <= r_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      cout_final_q <= cout_final_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic: load in IDLE, one adder byte per cycle in ADD, handshake out in DRAIN.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    r_d          = r_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    cout_final_d = cout_final_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          carry_d      = cin;
          cnt_d        = '0;
          cout_final_d = 1'b0;
          state_d      = ADD;
        end else begin
          if (load_a) a_d = {din, a_q[W-1:8]};
          if (load_b) b_d = {din, b_q[W-1:8]};
        end
      end

      ADD: begin
        r_d     = {cla_sum, r_q[W-1:8]};
        carry_d = cla_cout;
        a_d     = a_q >> 8;
        b_d     = b_q >> 8;
        if (cnt_q == LAST) begin
          cout_final_d = cla_cout;
          cnt_d        = '0;
          state_d      = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DRAIN: begin
        if (out_ack) begin
          r_d = r_q >> 8;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cla_a      = a_q[7:0];
  assign cla_b      = b_q[7:0];
  assign cla_cin    = carry_q;
  assign dout       = r_q[7:0];
  assign dout_valid = (state_q == DRAIN);
  assign busy       = (state_q != IDLE);
  assign cout_final = cout_final_q;
  assign done       = done_q;

endmodule

// File: tb/tb_cla_operand_sequencer.sv
// Testbench for cla_operand_sequencer
// The stimulus side pushes hand-computed result bytes into a scoreboard queue.
// An independent monitor pops and compares each byte as it is handshaken out.
module tb_cla_operand_sequencer;

   localparam int NBYTES = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] din;
   logic       load_a;
   logic       load_b;
   logic       cin;
   logic       start;
   logic       out_ack;
   logic [7:0] cla_a;
   logic [7:0] cla_b;
   logic       cla_cin;
   logic [7:0] cla_sum;
   logic       cla_cout;
   logic [7:0] dout;
   logic       dout_valid;
   logic       busy;
   logic       cout_final;
   logic       done;

   typedef struct {
      logic [7:0] val;
      bit         last;
      bit         cf;
   } exp_t;

   exp_t sb[$];
   int   checks_total  = 0;
   int   checks_passed = 0;
   int   ack_gap       = 0;

   cla_operand_sequencer #(.NBYTES(NBYTES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .din        (din),
      .load_a     (load_a),
      .load_b     (load_b),
      .cin        (cin),
      .start      (start),
      .out_ack    (out_ack),
      .cla_a      (cla_a),
      .cla_b      (cla_b),
      .cla_cin    (cla_cin),
      .cla_sum    (cla_sum),
      .cla_cout   (cla_cout),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .cout_final (cout_final),
      .done       (done)
   );

   // Behavioural model of the external 8-bit adder core
   assign {cla_cout, cla_sum} = 9'(cla_a) + 9'(cla_b) + 9'(cla_cin);

   // 100 MHz clock
   always #5 clk = ~clk;

   // Safety net so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Loads A then B byte-serially, queues the expected result bytes, then pulses start
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic c,
                                input logic [31:0] exp_sum, input logic exp_cf);
      exp_t e;
      for (int i = 0; i < NBYTES; i++) begin
         din = a[8*i +: 8];
         load_a = 1'b1;
         step();
      end
      load_a = 1'b0;
      for (int i = 0; i < NBYTES; i++) begin
         din = b[8*i +: 8];
         load_b = 1'b1;
         step();
      end
      load_b = 1'b0;
      for (int i = 0; i < NBYTES; i++) begin
         e.val  = exp_sum[8*i +: 8];
         e.last = (i == NBYTES - 1);
         e.cf   = exp_cf;
         sb.push_back(e);
      end
      cin   = c;
      start = 1'b1;
      step();
      start = 1'b0;
      cin   = 1'b0;
      din   = 8'h00;
   endtask

   // Waits, bounded, for the sequencer to return to IDLE and counts the cycles taken
   task automatic waitIdle(input string name, input int budget, inout int n);
      while (busy && n < budget) begin
         step();
         n++;
      end
      checkOutput({name, " idle"}, 32'(busy), 32'd0);
      step();
      step();
      checkOutput({name, " leftover"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " busy"},       32'(busy),       32'd0);
      checkOutput({tag, " dout_valid"}, 32'(dout_valid), 32'd0);
      checkOutput({tag, " dout"},       32'(dout),       32'd0);
      checkOutput({tag, " cla_a"},      32'(cla_a),      32'd0);
      checkOutput({tag, " cla_b"},      32'(cla_b),      32'd0);
      checkOutput({tag, " cla_cin"},    32'(cla_cin),    32'd0);
      checkOutput({tag, " cout_final"}, 32'(cout_final), 32'd0);
      checkOutput({tag, " done"},       32'(done),       32'd0);
   endtask

   // Consumer model: ack held high, or each byte acked after ack_gap waiting cycles
   initial begin
      int waitCnt;
      waitCnt = 0;
      out_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            out_ack = 1'b0;
            waitCnt = 0;
         end else if (ack_gap == 0) begin
            out_ack = 1'b1;
         end else if (out_ack) begin
            out_ack = 1'b0;
            waitCnt = 0;
         end else if (dout_valid) begin
            if (waitCnt >= ack_gap) out_ack = 1'b1;
            else waitCnt++;
         end
      end
   end

   // Monitor: pops the scoreboard on every handshake, checks done/cout_final and hold stability
   logic [7:0] heldDout;
   bit         holding     = 1'b0;
   bit         donePending = 1'b0;
   bit         pendCf      = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         holding     = 1'b0;
         donePending = 1'b0;
      end else begin
         if (donePending) begin
            checkOutput("done pulse", 32'(done), 32'd1);
            checkOutput("cout_final", 32'(cout_final), 32'(pendCf));
            donePending = 1'b0;
         end else begin
            checkOutput("done quiet", 32'(done), 32'd0);
         end
         if (holding) begin
            checkOutput("dout_valid held", 32'(dout_valid), 32'd1);
            checkOutput("dout held", 32'(dout), 32'(heldDout));
         end
         holding = 1'b0;
         if (ena && dout_valid) begin
            if (out_ack) begin
               if (sb.size() == 0) begin
                  checkOutput("unexpected byte", 32'(dout_valid), 32'd0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("dout byte", 32'(dout), 32'(e.val));
                  if (e.last) begin
                     donePending = 1'b1;
                     pendCf      = e.cf;
                  end
               end
            end else begin
               holding  = 1'b1;
               heldDout = dout;
            end
         end
      end
   end

   // Directed test sequence
   initial begin
      int n;
      rst_n  = 1'b0;
      ena    = 1'b1;
      din    = 8'h00;
      load_a = 1'b0;
      load_b = 1'b0;
      cin    = 1'b0;
      start  = 1'b0;
      #2;
      checkAllZero("reset");
      step();
      rst_n = 1'b1;
      step();

      $display("[TB] test 1: basic addition, ack held high");
      n = 0;
      applyStimulus(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0);
      waitIdle("t1", 100, n);
      checkOutput("t1 cycles", 32'(n), 32'd8);

      $display("[TB] test 2: full carry ripple");
      applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
      checkOutput("t2 cla_cin byte0", 32'(cla_cin), 32'd0);
      for (int i = 1; i < NBYTES; i++) begin
         step();
         checkOutput("t2 cla_cin ripple", 32'(cla_cin), 32'd1);
      end
      n = NBYTES - 1;
      waitIdle("t2", 100, n);

      $display("[TB] test 3: carry-in with all-ones operand");
      n = 0;
      applyStimulus(32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1);
      waitIdle("t3", 100, n);

      $display("[TB] test 4: slow consumer");
      ack_gap = 5;
      step();
      n = 0;
      applyStimulus(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0);
      waitIdle("t4", 200, n);
      ack_gap = 0;
      step();

      $display("[TB] test 5: ignored controls and enable drop during ADD");
      n = 0;
      applyStimulus(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0);
      step();
      n++;
      start  = 1'b1;
      load_a = 1'b1;
      din    = 8'hFF;
      step();
      n++;
      start  = 1'b0;
      load_a = 1'b0;
      din    = 8'h00;
      ena    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n++;
      end
      checkOutput("t5 frozen cla_a", 32'(cla_a), 32'h34);
      checkOutput("t5 frozen busy", 32'(busy), 32'd1);
      ena = 1'b1;
      waitIdle("t5", 100, n);
      checkOutput("t5 cycles", 32'(n), 32'd11);

      $display("[TB] test 6: reset mid-ADD then recovery");
      applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
      step();
      step();
      rst_n = 1'b0;
      #1;
      checkAllZero("t6 reset");
      sb.delete();
      step();
      rst_n = 1'b1;
      step();
      n = 0;
      applyStimulus(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0);
      waitIdle("t6", 100, n);
      checkOutput("t6 cycles", 32'(n), 32'd8);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
